// File: rtl/rollback_sequencer_pkg.sv
// Shared types, widths and helpers for the rollback sequencer.
// Widths follow the core's NUM_ROB / NUM_FL / NUM_LSQ macros; standalone defaults are provided.
`ifndef NUM_ROB
`define NUM_ROB 32
`endif
`ifndef NUM_FL
`define NUM_FL 64
`endif
`ifndef NUM_LSQ
`define NUM_LSQ 16
`endif

package rollback_sequencer_pkg;

    localparam int ROB_W = $clog2(`NUM_ROB);
    localparam int FL_W  = $clog2(`NUM_FL);
    localparam int LSQ_W = $clog2(`NUM_LSQ);

    localparam logic [63:0] BADDR = 64'h0;

    typedef struct packed {
        logic [ROB_W-1:0] rob_idx;
        logic [FL_W-1:0]  fl_idx;
        logic [LSQ_W-1:0] sq_idx;
        logic [LSQ_W-1:0] lq_idx;
        logic [63:0]      target_pc;
    } ROLLBACK_REQ_t;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        DRAIN
    } RS_STATE_t;

    // Distance back from the reference tail; wrap-around falls out of the modular subtraction.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] ref_idx,
                                                 input logic [ROB_W-1:0] idx);
        return ref_idx - idx;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/rollback_sequencer_if.sv
// Rollback request / restore bundle between FU+LQ (master) and the rollback sequencer (slave).
interface rollback_sequencer_if
    import rollback_sequencer_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                req_valid;
    ROLLBACK_REQ_t [NUM_REQ-1:0]       req;
    logic [ROB_W-1:0]                  rob_tail_idx;

    logic                              rollback_en;
    logic [ROB_W-1:0]                  rob_rollback_idx;
    logic [FL_W-1:0]                   fl_rollback_idx;
    logic [LSQ_W-1:0]                  sq_rollback_idx;
    logic [LSQ_W-1:0]                  lq_rollback_idx;
    logic [63:0]                       redirect_pc;
    logic [ROB_W-1:0]                  diff_rob;
    logic                              dispatch_stall;
    logic                              busy;

    modport master (
        output req_valid, req, rob_tail_idx,
        input  rollback_en, rob_rollback_idx, fl_rollback_idx, sq_rollback_idx,
               lq_rollback_idx, redirect_pc, diff_rob, dispatch_stall, busy
    );

    modport slave (
        input  req_valid, req, rob_tail_idx,
        output rollback_en, rob_rollback_idx, fl_rollback_idx, sq_rollback_idx,
               lq_rollback_idx, redirect_pc, diff_rob, dispatch_stall, busy
    );
endinterface

// File: rtl/rollback_sequencer_age_select.sv
// Combinational oldest-of-N picker: largest (ref - rob_idx) among valid slots,
// lowest slot index wins ties so branches beat loads at the same ROB entry.
module rollback_age_select
    import rollback_sequencer_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic [NUM_REQ-1:0]            valid_i,
    input  logic [NUM_REQ-1:0][ROB_W-1:0] rob_idx_i,
    input  logic [ROB_W-1:0]              ref_i,
    output logic                          win_valid_o,
    output logic [IDX_W-1:0]              win_idx_o,
    output logic [ROB_W-1:0]              win_age_o
);

    always_comb begin
        // NOTE: every output is given a default before the loop, so no path leaves one unassigned and no latch is inferred.
        win_valid_o = 1'b0;
        win_idx_o   = '0;
        win_age_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid_i[i] && (!win_valid_o || rob_age(ref_i, rob_idx_i[i]) > win_age_o)) begin
                win_valid_o = 1'b1;
                win_idx_o   = IDX_W'(i);
                win_age_o   = rob_age(ref_i, rob_idx_i[i]);
            end
        end
    end

endmodule

// File: rtl/rollback_sequencer.sv
// Picks the oldest rollback request, pulses the restore indices for one cycle and freezes
// dispatch for DRAIN_CYCLES; older requests preempt the window. ROLLBACK_STATS_EN adds counters.
module rollback_sequencer
    import rollback_sequencer_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NUM_BR       = 2,
    parameter int DRAIN_CYCLES = 2
)
(
    input  logic                 clock,
    input  logic                 reset,
    rollback_sequencer_if.slave  bus
`ifdef ROLLBACK_STATS_EN
    ,
    output logic [31:0]          br_rollback_cnt_o,
    output logic [31:0]          ld_rollback_cnt_o,
    output logic [31:0]          discard_cnt_o
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    RS_STATE_t        state_q;
    logic [ROB_W-1:0] ref_tail_q;
    logic [ROB_W-1:0] sel_age_q;
    logic [CNT_W-1:0] drain_cnt_q;
    logic             rollback_en_q;
    logic             dispatch_stall_q;
    logic             busy_q;
    logic [ROB_W-1:0] rob_idx_q;
    logic [FL_W-1:0]  fl_idx_q;
    logic [LSQ_W-1:0] sq_idx_q;
    logic [LSQ_W-1:0] lq_idx_q;
    logic [63:0]      redirect_pc_q;
    logic [ROB_W-1:0] diff_rob_q;

    logic [NUM_REQ-1:0][ROB_W-1:0] req_rob_idx;
    logic [ROB_W-1:0]              age_ref;
    logic                          win_valid;
    logic [IDX_W-1:0]              win_idx;
    logic [ROB_W-1:0]              win_age;
    ROLLBACK_REQ_t                 win_req;
    logic                          take;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rob_idx[i] = bus.req[i].rob_idx;
        end
    end

    // Live tail while idle; the tail latched at selection while a recovery is in flight.
    assign age_ref = (state_q == IDLE) ? bus.rob_tail_idx : ref_tail_q;

    rollback_age_select #(.NUM_REQ(NUM_REQ)) u_age_select (
        .valid_i     (bus.req_valid),
        .rob_idx_i   (req_rob_idx),
        .ref_i       (age_ref),
        .win_valid_o (win_valid),
        .win_idx_o   (win_idx),
        .win_age_o   (win_age)
    );

    assign win_req = bus.req[win_idx];
    assign take    = win_valid && ((state_q == IDLE) || (win_age > sel_age_q));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            ref_tail_q       <= '0;
            sel_age_q        <= '0;
            drain_cnt_q      <= '0;
            rollback_en_q    <= 1'b0;
            dispatch_stall_q <= 1'b0;
            busy_q           <= 1'b0;
            rob_idx_q        <= '0;
            fl_idx_q         <= '0;
            sq_idx_q         <= '0;
            lq_idx_q         <= '0;
            redirect_pc_q    <= BADDR;
            diff_rob_q       <= '0;
        end else if (take) begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
            if (state_q == IDLE) begin
                ref_tail_q <= bus.rob_tail_idx;
            end
            sel_age_q        <= win_age;
            rob_idx_q        <= win_req.rob_idx;
            fl_idx_q         <= win_req.fl_idx;
            sq_idx_q         <= win_req.sq_idx;
            lq_idx_q         <= win_req.lq_idx;
            redirect_pc_q    <= win_req.target_pc;
            diff_rob_q       <= win_age;
            rollback_en_q    <= 1'b1;
            dispatch_stall_q <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= FIRE;
        end else begin
            case (state_q)
                IDLE: begin
                    rollback_en_q    <= 1'b0;
                    dispatch_stall_q <= 1'b0;
                    busy_q           <= 1'b0;
                end
                FIRE: begin
                    rollback_en_q <= 1'b0;
                    drain_cnt_q   <= CNT_W'(DRAIN_CYCLES);
                    state_q       <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt_q == CNT_W'(1)) begin
                        drain_cnt_q      <= '0;
                        dispatch_stall_q <= 1'b0;
                        busy_q           <= 1'b0;
                        state_q          <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rollback_en      = rollback_en_q;
    assign bus.rob_rollback_idx = rob_idx_q;
    assign bus.fl_rollback_idx  = fl_idx_q;
    assign bus.sq_rollback_idx  = sq_idx_q;
    assign bus.lq_rollback_idx  = lq_idx_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.diff_rob         = diff_rob_q;
    assign bus.dispatch_stall   = dispatch_stall_q;
    assign bus.busy             = busy_q;

`ifdef ROLLBACK_STATS_EN
    localparam int DISC_W = $clog2(NUM_REQ + 1);

    logic              out_is_br_q;
    logic [DISC_W-1:0] discard_n;
    logic [31:0]       br_cnt_q;
    logic [31:0]       ld_cnt_q;
    logic [31:0]       discard_cnt_q;

    // Requests no older than the recovery in flight are squashed by it and dropped.
    always_comb begin
        discard_n = '0;
        if (state_q != IDLE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && rob_age(ref_tail_q, bus.req[i].rob_idx) <= sel_age_q) begin
                    discard_n = discard_n + DISC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_is_br_q   <= 1'b0;
            br_cnt_q      <= '0;
            ld_cnt_q      <= '0;
            discard_cnt_q <= '0;
        end else begin
            if (take) begin
                out_is_br_q <= (int'(win_idx) < NUM_BR);
            end
            if (rollback_en_q) begin
                if (out_is_br_q) br_cnt_q <= sat_add(br_cnt_q, 32'd1);
                else             ld_cnt_q <= sat_add(ld_cnt_q, 32'd1);
            end
            discard_cnt_q <= sat_add(discard_cnt_q, 32'(discard_n));
        end
    end

    assign br_rollback_cnt_o = br_cnt_q;
    assign ld_rollback_cnt_o = ld_cnt_q;
    assign discard_cnt_o     = discard_cnt_q;
`endif

endmodule

// File: tb/tb_rollback_sequencer.sv
// Scoreboard bench for rollback_sequencer: a countdown-style recovery model predicts pulses and
// busy per cycle; a negedge monitor pops and compares them.
module tb_rollback_sequencer;
    import rollback_sequencer_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int NUM_BR       = 2;
    localparam int DRAIN_CYCLES = 2;
    localparam int ROB_N        = 1 << ROB_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rollback_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef ROLLBACK_STATS_EN
    logic [31:0] br_cnt, ld_cnt, disc_cnt;
`endif

    rollback_sequencer #(
        .NUM_REQ      (NUM_REQ),
        .NUM_BR       (NUM_BR),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef ROLLBACK_STATS_EN
        ,
        .br_rollback_cnt_o (br_cnt),
        .ld_rollback_cnt_o (ld_cnt),
        .discard_cnt_o     (disc_cnt)
`endif
    );

    typedef struct {
        int               cyc;
        logic [ROB_W-1:0] rob;
        logic [FL_W-1:0]  fl;
        logic [LSQ_W-1:0] sq;
        logic [LSQ_W-1:0] lq;
        logic [63:0]      pc;
        logic [ROB_W-1:0] diff;
    } pulse_t;

    typedef struct {
        int   cyc;
        logic busy;
    } busy_t;

    pulse_t        pulse_q[$];
    busy_t         busy_q[$];
    ROLLBACK_REQ_t stim[NUM_REQ];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: cycles of busy still ahead, tail latched at acceptance, age of the recovery in flight.
    int m_left = 0;
    int m_ref  = 0;
    int m_sel  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: actual 0x%0h required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int slot, input int rob, input int fl, input int sq, input int lq,
                           input logic [63:0] pc);
        stim[slot].rob_idx   = ROB_W'(rob);
        stim[slot].fl_idx    = FL_W'(fl);
        stim[slot].sq_idx    = LSQ_W'(sq);
        stim[slot].lq_idx    = LSQ_W'(lq);
        stim[slot].target_pc = pc;
    endtask

    // Drive one cycle of inputs and predict what the DUT shows in the following cycle.
    task automatic step(input logic rst, input logic [NUM_REQ-1:0] v, input int tail);
        int best, best_age, r, a;
        @(posedge clock);
        #1;
        reset            = rst;
        bus.req_valid    = v;
        bus.rob_tail_idx = ROB_W'(tail);
        for (int i = 0; i < NUM_REQ; i++) bus.req[i] = stim[i];

        best     = -1;
        best_age = -1;
        r        = (m_left == 0) ? (tail % ROB_N) : m_ref;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) begin
                a = (r - int'(stim[i].rob_idx) + ROB_N) % ROB_N;
                if (a > best_age) begin
                    best_age = a;
                    best     = i;
                end
            end
        end

        if (rst) begin
            m_left = 0;
        end else if (best >= 0 && (m_left == 0 || best_age > m_sel)) begin
            if (m_left == 0) m_ref = tail % ROB_N;
            m_sel  = best_age;
            m_left = 1 + DRAIN_CYCLES;
            pulse_q.push_back('{cyc + 1, stim[best].rob_idx, stim[best].fl_idx, stim[best].sq_idx,
                                stim[best].lq_idx, stim[best].target_pc, ROB_W'(best_age)});
        end else if (m_left > 0) begin
            m_left--;
        end
        busy_q.push_back('{cyc + 1, m_left > 0});
    endtask

    task automatic idle(input int n, input int tail);
        for (int i = 0; i < n; i++) step(1'b0, '0, tail);
    endtask

    task automatic check_reset_outputs();
        check("rst_rollback_en", 64'(bus.rollback_en), 64'd0);
        check("rst_rob_idx", 64'(bus.rob_rollback_idx), 64'd0);
        check("rst_fl_idx", 64'(bus.fl_rollback_idx), 64'd0);
        check("rst_sq_idx", 64'(bus.sq_rollback_idx), 64'd0);
        check("rst_lq_idx", 64'(bus.lq_rollback_idx), 64'd0);
        check("rst_redirect_pc", bus.redirect_pc, 64'd0);
        check("rst_diff_rob", 64'(bus.diff_rob), 64'd0);
        check("rst_dispatch_stall", 64'(bus.dispatch_stall), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
    endtask

    // Monitor: compares every driven cycle against the scoreboard entries tagged for it.
    initial begin
        busy_t  b;
        pulse_t p;
        forever begin
            @(negedge clock);
            while (busy_q.size() > 0 && busy_q[0].cyc < cyc) void'(busy_q.pop_front());
            if (busy_q.size() > 0 && busy_q[0].cyc == cyc) begin
                b = busy_q.pop_front();
                check("busy", 64'(bus.busy), 64'(b.busy));
                check("dispatch_stall", 64'(bus.dispatch_stall), 64'(b.busy));
                if (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
                    p = pulse_q.pop_front();
                    check("rollback_en", 64'(bus.rollback_en), 64'd1);
                    check("rob_rollback_idx", 64'(bus.rob_rollback_idx), 64'(p.rob));
                    check("fl_rollback_idx", 64'(bus.fl_rollback_idx), 64'(p.fl));
                    check("sq_rollback_idx", 64'(bus.sq_rollback_idx), 64'(p.sq));
                    check("lq_rollback_idx", 64'(bus.lq_rollback_idx), 64'(p.lq));
                    check("redirect_pc", bus.redirect_pc, p.pc);
                    check("diff_rob", 64'(bus.diff_rob), 64'(p.diff));
                end else begin
                    check("rollback_en_idle", 64'(bus.rollback_en), 64'd0);
                end
            end
        end
    end

    initial begin
        bus.req_valid    = '0;
        bus.rob_tail_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 0, 0, 0, 0, 64'h0);
            bus.req[i] = stim[i];
        end

        step(1'b1, '0, 0);
        step(1'b1, '0, 0);
        step(1'b0, '0, 0);
        check_reset_outputs();
        idle(2, 0);

        // Single branch: age 4, pulse then two drain cycles.
        set_req(0, 5, 3, 1, 2, 64'h1000);
        step(1'b0, 4'b0001, 9);
        idle(5, 9);

        // Race: load at rob 4 (age 6) beats branch at rob 7 (age 3).
        set_req(1, 7, 10, 4, 5, 64'h2000);
        set_req(2, 4, 11, 6, 7, 64'h3000);
        step(1'b0, 4'b0110, 10);
        idle(5, 10);

        // Tie at rob 4: slot 0 beats slot 2.
        set_req(0, 4, 12, 8, 9, 64'h4000);
        step(1'b0, 4'b0101, 10);
        idle(5, 10);

        // Wrap: tail 2, rob 30 (age 4) beats rob 1 (age 1).
        set_req(0, 30, 20, 3, 3, 64'h5000);
        set_req(3, 1, 21, 4, 4, 64'h6000);
        step(1'b0, 4'b1001, 2);
        idle(5, 2);

        // Drain: younger request dropped, older one preempts against the latched tail.
        set_req(0, 5, 3, 1, 2, 64'h7000);
        step(1'b0, 4'b0001, 9);
        step(1'b0, '0, 10);
        set_req(1, 8, 30, 9, 9, 64'h8000);
        step(1'b0, 4'b0010, 12);
        set_req(2, 3, 31, 10, 11, 64'h9000);
        step(1'b0, 4'b0100, 12);
        idle(6, 12);

        // Reset mid-drain with a request still valid.
        set_req(0, 5, 3, 1, 2, 64'hA000);
        step(1'b0, 4'b0001, 9);
        idle(2, 9);
        step(1'b1, 4'b0001, 9);
        step(1'b0, '0, 9);
        check_reset_outputs();
        idle(4, 9);
        step(1'b0, 4'b0001, 9);
        idle(5, 9);

        // Randomized traffic with a drifting tail and rare resets.
        begin
            int tail = 0;
            logic [NUM_REQ-1:0] v;
            for (int n = 0; n < 600; n++) begin
                tail = (tail + int'($urandom_range(0, 1))) % ROB_N;
                for (int i = 0; i < NUM_REQ; i++) begin
                    v[i] = ($urandom_range(0, 4) == 0);
                    set_req(i, int'($urandom_range(0, ROB_N - 1)), int'($urandom_range(0, 63)),
                            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                            {$urandom(), $urandom()});
                end
                step($urandom_range(0, 99) == 0, v, tail);
            end
            idle(6, tail);
        end

        check("pending_pulses", 64'(pulse_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
